// File: rtl/bf16_add.sv
// BFloat16 adder: one combinational add/round stage feeding the output register.
// Subnormal inputs are flushed to zero and subnormal results are never produced.
module bf16_add (
  input  logic       clk,
  input  logic       nreset,
  input  logic       sa_i,
  input  logic [7:0] ea_i,
  input  logic [6:0] ma_i,
  input  logic       sb_i,
  input  logic [7:0] eb_i,
  input  logic [6:0] mb_i,
  output logic       s_o,
  output logic [7:0] e_o,
  output logic [6:0] m_o
);

  logic              a_zero, a_inf, a_nan;
  logic              b_zero, b_inf, b_nan;
  logic              swap;
  logic              sx, sy;
  logic [7:0]        ex, ey, diff;
  logic [6:0]        mx, my;
  logic [10:0]       sig_x, sig_y, sig_y_sh;
  logic [20:0]       wide;
  logic [11:0]       sum;
  logic [9:0]        norm;
  logic [3:0]        lzc;
  logic              fin_zero;
  logic signed [9:0] exp_n, exp_r;
  logic [7:0]        mant_r;
  logic              rnd_up;
  logic              res_s;
  logic [7:0]        res_e;
  logic [6:0]        res_m;

  function automatic logic [3:0] lzc11(input logic [10:0] v);
    logic [3:0] n;
    n = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (v[i]) n = 4'(10 - i);
    end
    return n;
  endfunction

  assign a_zero = (ea_i == 8'h00);
  assign a_inf  = (ea_i == 8'hFF) && (ma_i == 7'd0);
  assign a_nan  = (ea_i == 8'hFF) && (ma_i != 7'd0);
  assign b_zero = (eb_i == 8'h00);
  assign b_inf  = (eb_i == 8'hFF) && (mb_i == 7'd0);
  assign b_nan  = (eb_i == 8'hFF) && (mb_i != 7'd0);

  // X always holds the larger magnitude so the subtraction below never goes negative.
  assign swap  = {eb_i, mb_i} > {ea_i, ma_i};
  assign sx    = swap ? sb_i : sa_i;
  assign sy    = swap ? sa_i : sb_i;
  assign ex    = swap ? eb_i : ea_i;
  assign ey    = swap ? ea_i : eb_i;
  assign mx    = swap ? mb_i : ma_i;
  assign my    = swap ? ma_i : mb_i;
  assign diff  = ex - ey;
  assign sig_x = {1'b1, mx, 3'b000};
  assign sig_y = {1'b1, my, 3'b000};

  always_comb begin
    wide = {sig_y, 10'd0} >> diff;
    if (diff >= 8'd10) begin
      sig_y_sh = 11'd1;
    end else begin
      sig_y_sh = wide[20:10] | {10'd0, |wide[9:0]};
    end
  end

  // norm holds the fraction below the hidden bit: 7 mantissa bits then G, R, S.
  always_comb begin
    sum      = '0;
    norm     = '0;
    lzc      = '0;
    exp_n    = '0;
    fin_zero = 1'b0;
    if (sx == sy) begin
      sum = {1'b0, sig_x} + {1'b0, sig_y_sh};
      if (sum[11]) begin
        norm  = {sum[10:2], sum[1] | sum[0]};
        exp_n = $signed({2'b00, ex}) + 10'sd1;
      end else begin
        norm  = sum[9:0];
        exp_n = $signed({2'b00, ex});
      end
    end else begin
      sum = {1'b0, sig_x} - {1'b0, sig_y_sh};
      if (sum[10:0] == 11'd0) begin
        fin_zero = 1'b1;
      end else begin
        lzc   = lzc11(sum[10:0]);
        norm  = sum[9:0] << lzc;
        exp_n = $signed({2'b00, ex}) - $signed({6'd0, lzc});
      end
    end
  end

  assign rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign mant_r = {1'b0, norm[9:3]} + {7'd0, rnd_up};
  assign exp_r  = exp_n + (mant_r[7] ? 10'sd1 : 10'sd0);

  always_comb begin
    res_s = 1'b0;
    res_e = 8'h00;
    res_m = 7'd0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa_i != sb_i))) begin
      res_e = 8'hFF;
      res_m = 7'h40;
    end else if (a_inf) begin
      res_s = sa_i;
      res_e = 8'hFF;
    end else if (b_inf) begin
      res_s = sb_i;
      res_e = 8'hFF;
    end else if (a_zero && b_zero) begin
      res_s = sa_i & sb_i;
    end else if (a_zero) begin
      res_s = sb_i;
      res_e = eb_i;
      res_m = mb_i;
    end else if (b_zero) begin
      res_s = sa_i;
      res_e = ea_i;
      res_m = ma_i;
    end else if (fin_zero) begin
      res_s = 1'b0;
    end else if (exp_n <= 10'sd0) begin
      res_s = sx;
    end else if (exp_r >= 10'sd255) begin
      res_s = sx;
      res_e = 8'hFF;
    end else begin
      res_s = sx;
      res_e = exp_r[7:0];
      res_m = mant_r[6:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      s_o <= 1'b0;
      e_o <= 8'h00;
      m_o <= 7'd0;
    end else begin
      s_o <= res_s;
      e_o <= res_e;
      m_o <= res_m;
    end
  end

endmodule

// File: tb/tb_bf16_add.sv
// Self-checking bench for bf16_add: directed vectors, hold/reset timing and
// randomized operands against a real-arithmetic reference model.
module tb_bf16_add;

  logic       clk = 1'b0;
  logic       nreset;
  logic       sa, sb;
  logic [7:0] ea, eb;
  logic [6:0] ma, mb;
  logic       s_out;
  logic [7:0] e_out;
  logic [6:0] m_out;
  logic [15:0] sum_word;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] vec_a    [0:14] = '{16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h8000,
                                   16'h3F80, 16'h3F80, 16'h3F81, 16'h3F80, 16'h3F81,
                                   16'h4040, 16'h7F7F, 16'h7F80, 16'hFF80, 16'h7FC1};
  logic [15:0] vec_b    [0:14] = '{16'h0000, 16'h8000, 16'h8000, 16'hBF80, 16'h3F80,
                                   16'hBF80, 16'h3B80, 16'h3B80, 16'h0001, 16'hBF80,
                                   16'hBF80, 16'h7F7F, 16'hFF80, 16'h3F80, 16'h3F80};
  logic [15:0] vec_want [0:14] = '{16'h0000, 16'h0000, 16'h8000, 16'hBF80, 16'h3F80,
                                   16'h0000, 16'h3F80, 16'h3F82, 16'h3F80, 16'h3C00,
                                   16'h4000, 16'h7F80, 16'h7FC0, 16'hFF80, 16'h7FC0};
  logic [15:0] spec_vals [0:7] = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80,
                                   16'h7FC0, 16'h0001, 16'h0080, 16'h7F7F};

  bf16_add dut (
    .clk    (clk),
    .nreset (nreset),
    .sa_i   (sa),
    .ea_i   (ea),
    .ma_i   (ma),
    .sb_i   (sb),
    .eb_i   (eb),
    .mb_i   (mb),
    .s_o    (s_out),
    .e_o    (e_out),
    .m_o    (m_out)
  );

  assign sum_word = {s_out, e_out, m_out};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %04h, want %04h", tag, got, want);
    end
  endtask

  // Reference: sum the operands as exact doubles, then round to BF16 with RNE.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [63:0] da, db, dr;
    real         r;
    int          e;
    logic [6:0]  m7;
    logic [7:0]  mm;
    logic        up;
    a_zero = (a[14:7] == 8'h00);
    b_zero = (b[14:7] == 8'h00);
    a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
    b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
    a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
    b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
    if (a_nan || b_nan) return 16'h7FC0;
    if (a_inf && b_inf && (a[15] != b[15])) return 16'h7FC0;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {a[15] & b[15], 15'd0};
    if (a_zero) return b;
    if (b_zero) return a;
    da = {a[15], (11'(a[14:7]) + 11'd896), a[6:0], 45'd0};
    db = {b[15], (11'(b[14:7]) + 11'd896), b[6:0], 45'd0};
    r  = $bitstoreal(da) + $bitstoreal(db);
    if (r == 0.0) return 16'h0000;
    dr = $realtobits(r);
    e  = int'(dr[62:52]) - 896;
    if (e <= 0) return {dr[63], 15'd0};
    m7 = dr[51:45];
    up = dr[44] & ((|dr[43:0]) | m7[0]);
    mm = {1'b0, m7} + {7'd0, up};
    if (mm[7]) e++;
    if (e >= 255) return {dr[63], 8'hFF, 7'd0};
    return {dr[63], 8'(e), mm[6:0]};
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b);
    {sa, ea, ma} = a;
    {sb, eb, mb} = b;
  endtask

  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] want);
    drive(a, b);
    @(posedge clk);
    #1;
    $display("[TB] %s %04h + %04h -> %04h (want %04h)", tag, a, b, sum_word, want);
    check_eq(tag, sum_word, want);
  endtask

  initial begin
    logic [15:0] a, b;
    int          mode, eb_off;

    nreset = 1'b0;
    drive(16'h3F80, 16'h3F80);
    repeat (2) begin
      @(posedge clk);
      #1;
      $display("[TB] reset 3f80 + 3f80 -> %04h (want 0000)", sum_word);
      check_eq("reset", sum_word, 16'h0000);
    end
    nreset = 1'b1;
    step("reset_release", 16'h3F80, 16'h3F80, 16'h4000);

    // Directed vectors back-to-back, one per cycle.
    for (int i = 0; i < 15; i++) begin
      step($sformatf("vec%0d", i), vec_a[i], vec_b[i], vec_want[i]);
    end

    // Mid-cycle input changes and a reset glitch between edges must not touch the outputs.
    step("hold_base", 16'h3F80, 16'h3F80, 16'h4000);
    drive(16'h4040, 16'h3F80);
    #2;
    nreset = 1'b0;
    #2;
    nreset = 1'b1;
    $display("[TB] hold between edges -> %04h (want 4000)", sum_word);
    check_eq("hold", sum_word, 16'h4000);
    @(posedge clk);
    #1;
    $display("[TB] reset glitch ignored 4040 + 3f80 -> %04h (want 4080)", sum_word);
    check_eq("glitch_ignored", sum_word, 16'h4080);

    // Asserting reset between edges clears only at the next edge.
    drive(16'h3F80, 16'h3F80);
    #2;
    nreset = 1'b0;
    #1;
    check_eq("reset_not_async", sum_word, 16'h4080);
    @(posedge clk);
    #1;
    $display("[TB] reset sampled -> %04h (want 0000)", sum_word);
    check_eq("reset_sync", sum_word, 16'h0000);
    nreset = 1'b1;

    for (int i = 0; i < 400; i++) begin
      a    = 16'($urandom);
      mode = int'($urandom_range(0, 4));
      case (mode)
        0: b = 16'($urandom);
        1: begin
          eb_off = int'(a[14:7]) + int'($urandom_range(0, 6)) - 3;
          b = {~a[15], 8'(eb_off), 7'($urandom)};
        end
        2: b = a ^ 16'h8000 ^ {9'd0, 7'($urandom_range(0, 3))};
        3: begin
          a = {a[15], 8'($urandom_range(1, 3)), a[6:0]};
          b = {~a[15], 8'($urandom_range(1, 3)), 7'($urandom)};
        end
        default: b = spec_vals[$urandom_range(0, 7)];
      endcase
      step("rand", a, b, ref_add(a, b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
